airi5c_dm_hartctrl: RTL

// - Debug Module control stage directly upstream of the debug ROM. It decodes DMI register accesses
//   (dmcontrol, dmstatus, abstractcs, command, data0, progbuf0/1) into ROM-side controls and reports ROM state back.
// - Drives haltreq to the core; postexec_req, resume_req, progbuf0/1 to the ROM. Consumes halted, resume_ack, postexec_pending.

---
 rtl/airi5c_dm_pkg.sv | 29 ++
 rtl/airi5c_dm_hartctrl_if.sv | 13 +
 rtl/airi5c_dm_cmd_fsm.sv | 66 ++++++
 rtl/airi5c_dm_hartctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/airi5c_dm_pkg.sv
// Shared Debug Module definitions: DMI register map, op codes, cmderr codes, command FSM states.
package airi5c_dm_pkg;
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [6:0] ADDR_PROGBUF0   = 7'h20;
  localparam logic [6:0] ADDR_PROGBUF1   = 7'h21;

  typedef enum logic [1:0] {DMI_NOP = 2'd0, DMI_READ = 2'd1, DMI_WRITE = 2'd2} dmi_op_e;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPT     = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_SET, ST_WAIT_CLR} cmd_state_e;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  // Only "run progbuf" is supported: cmdtype 0, postexec set, no register transfer.
  function automatic logic cmd_supported(input logic [31:0] cmd);
    return (cmd[31:24] == 8'd0) && cmd[18] && !cmd[17];
  endfunction
endpackage

// File: rtl/airi5c_dm_hartctrl_if.sv
// DMI request/response channel between the debug transport and the hart control stage.
interface airi5c_dm_hartctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  addr;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (output req_valid, addr, op, wdata, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, addr, op, wdata, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/airi5c_dm_cmd_fsm.sv
// Abstract command sequencer: pulses postexec to the ROM and tracks the hart through progbuf execution.
// DM_CMD_TIMEOUT_EN adds a watchdog that aborts a stuck command.
module airi5c_dm_cmd_fsm
  import airi5c_dm_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  input  logic start,
  input  logic halted,
  input  logic postexec_pending,
  output logic postexec_req,
  output logic busy,
  output logic timeout
);
  cmd_state_e state, state_nxt;
  logic       expired;

`ifdef DM_CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  logic                 waiting;
  assign waiting = (state == ST_WAIT_SET) || (state == ST_WAIT_CLR);
  assign expired = waiting && (&cnt);

  // Runs across both wait states so the whole ROM round-trip is bounded.
  always_ff @(posedge clk or negedge nreset)
    if (!nreset)                         cnt <= '0;
    else if (clr || !waiting || expired) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
`else
  logic [TIMEOUT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
  assign expired    = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt    = state;
    postexec_req = 1'b0;
    busy         = 1'b1;
    timeout      = expired;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        postexec_req = 1'b1;
        state_nxt    = ST_WAIT_SET;
      end
      ST_WAIT_SET:
        if (expired)               state_nxt = ST_IDLE;
        else if (postexec_pending) state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR:
        if (expired)                           state_nxt = ST_IDLE;
        else if (!postexec_pending && halted)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) state_nxt = ST_IDLE;
  end
endmodule

// File: rtl/airi5c_dm_hartctrl.sv
// DM hart control: decodes DMI register accesses into debug-ROM controls and reports ROM state.
// Optional DM_CMD_TIMEOUT_EN enables the abstract-command timeout in airi5c_dm_cmd_fsm.
module airi5c_dm_hartctrl
  import airi5c_dm_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                nreset,
  airi5c_dm_hartctrl_if.slave dmi,
  output logic                haltreq,
  output logic                ndmreset,
  output logic                postexec_req,
  output logic                resume_req,
  output logic [31:0]         progbuf0,
  output logic [31:0]         progbuf1,
  input  logic                halted,
  input  logic                resume_ack,
  input  logic                postexec_pending
);
  logic        dmactive, haltreq_r, sticky, busy, timeout;
  logic [2:0]  cmderr, busy_err;
  logic [31:0] data0, rdata, resp_data;
  logic        resp_valid, acc, wr, clr, start;

  assign dmi.req_ready  = !resp_valid;
  assign dmi.resp_valid = resp_valid;
  assign dmi.resp_data  = resp_data;

  assign acc      = dmi.req_valid && dmi.req_ready;
  assign wr       = acc && (dmi.op == DMI_WRITE);
  assign clr      = wr && (dmi.addr == ADDR_DMCONTROL) && !dmi.wdata[0];
  assign start    = wr && (dmi.addr == ADDR_COMMAND) && !busy && (cmderr == CMDERR_NONE)
                    && cmd_supported(dmi.wdata) && halted;
  assign haltreq  = haltreq_r && dmactive;
  // The first error sticks; later busy violations leave it untouched.
  assign busy_err = (cmderr == CMDERR_NONE) ? CMDERR_BUSY : cmderr;

  airi5c_dm_cmd_fsm #(.TIMEOUT_W(TIMEOUT_W)) u_cmd_fsm (
    .clk              (clk),
    .nreset           (nreset),
    .clr              (clr),
    .start            (start),
    .halted           (halted),
    .postexec_pending (postexec_pending),
    .postexec_req     (postexec_req),
    .busy             (busy),
    .timeout          (timeout)
  );

  always_comb begin
    rdata = '0;
    if (dmi.op == DMI_READ)
      case (dmi.addr)
        ADDR_DMCONTROL:  rdata = {haltreq_r, 29'd0, ndmreset, dmactive};
        ADDR_DMSTATUS:   rdata = {14'd0, sticky, sticky, 4'd0, ~halted, ~halted, halted, halted,
                                  1'b1, 3'd0, 4'd2};
        ADDR_ABSTRACTCS: rdata = {3'd0, 5'd2, 11'd0, busy, 1'b0, cmderr, 4'd0, 4'd1};
        ADDR_DATA0:      rdata = data0;
        ADDR_PROGBUF0:   rdata = progbuf0;
        ADDR_PROGBUF1:   rdata = progbuf1;
        default:         rdata = '0;
      endcase
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      dmactive   <= 1'b0;
      haltreq_r  <= 1'b0;
      ndmreset   <= 1'b0;
      resume_req <= 1'b0;
      sticky     <= 1'b0;
      cmderr     <= CMDERR_NONE;
      data0      <= '0;
      progbuf0   <= NOP_INSN;
      progbuf1   <= NOP_INSN;
    end else begin
      resp_valid <= acc;
      resp_data  <= rdata;
      if (resume_req && resume_ack) begin
        resume_req <= 1'b0;
        sticky     <= 1'b1;
      end
      if (timeout) cmderr <= CMDERR_EXCEPT;
      if (wr)
        case (dmi.addr)
          ADDR_DMCONTROL: begin
            dmactive <= dmi.wdata[0];
            if (!dmi.wdata[0]) begin
              haltreq_r  <= 1'b0;
              ndmreset   <= 1'b0;
              resume_req <= 1'b0;
              sticky     <= 1'b0;
              cmderr     <= CMDERR_NONE;
              data0      <= '0;
              progbuf0   <= NOP_INSN;
              progbuf1   <= NOP_INSN;
            end else begin
              haltreq_r <= dmi.wdata[31];
              ndmreset  <= dmi.wdata[1];
              // A simultaneous haltreq suppresses the resume.
              if (dmi.wdata[30] && !dmi.wdata[31] && halted) begin
                resume_req <= 1'b1;
                sticky     <= 1'b0;
              end
            end
          end
          ADDR_ABSTRACTCS: cmderr <= cmderr & ~dmi.wdata[10:8];
          ADDR_COMMAND:
            if (busy)                                 cmderr <= busy_err;
            else if (cmderr == CMDERR_NONE) begin
              if (!cmd_supported(dmi.wdata))          cmderr <= CMDERR_NOTSUP;
              else if (!halted)                       cmderr <= CMDERR_HALTRESUME;
            end
          ADDR_DATA0:    if (busy) cmderr <= busy_err; else data0    <= dmi.wdata;
          ADDR_PROGBUF0: if (busy) cmderr <= busy_err; else progbuf0 <= dmi.wdata;
          ADDR_PROGBUF1: if (busy) cmderr <= busy_err; else progbuf1 <= dmi.wdata;
          default: ;
        endcase
    end
endmodule
